// File: rtl/pc_pkg.sv
// Shared types for the fetch-stage PC generator.
// src_e order encodes redirect priority: a higher value wins.
package pc_pkg;

    typedef enum logic [2:0] {
        SRC_NONE,
        SRC_BRANCH,
        SRC_JUMP,
        SRC_RET,
        SRC_FLUSH
    } src_e;

    localparam int unsigned INSTR_BYTES_DEFAULT = 4;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack.
// When full, a push overwrites the oldest entry. Only ptr/count are reset.
module ras_stack #(
    parameter int unsigned RAS_DEPTH = 4,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              clear_i,
    input  logic [ADDR_W-1:0] data_i,
    output logic [ADDR_W-1:0] top_o,
    output logic              empty_o,
    output logic              full_o
);

    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [PW-1:0] PtrOne  = PW'(1);
    localparam logic [CW-1:0] CntOne  = CW'(1);
    localparam logic [CW-1:0] CntFull = CW'(RAS_DEPTH);

    logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              wr_en;
    logic [PW-1:0]     wr_idx;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CntFull);
    assign top_o   = mem_q[ptr_q - PtrOne];

    always_comb begin
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        wr_en  = 1'b0;
        wr_idx = ptr_q;
        if (clear_i) begin
            ptr_d = '0;
            cnt_d = '0;
        end else if (push_i && pop_i && !empty_o) begin
            // Pop-then-push collapses to replacing the top in place.
            wr_en  = 1'b1;
            wr_idx = ptr_q - PtrOne;
        end else if (push_i) begin
            wr_en = 1'b1;
            ptr_d = ptr_q + PtrOne;
            if (!full_o) begin
                cnt_d = cnt_q + CntOne;
            end
        end else if (pop_i && !empty_o) begin
            ptr_d = ptr_q - PtrOne;
            cnt_d = cnt_q - CntOne;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= data_i;
        end
    end

endmodule

// File: rtl/pc_gen_ras.sv
// Fetch PC generator: prioritised redirects, stall-time redirect capture
// and a return-address stack for predicted returns.
module pc_gen_ras
    import pc_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int unsigned INSTR_BYTES = INSTR_BYTES_DEFAULT,
    parameter int unsigned RAS_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush_valid,
    input  logic [ADDR_W-1:0] flush_pc,
    input  logic              ret_valid,
    input  logic [ADDR_W-1:0] ret_fallback,
    input  logic              jump_valid,
    input  logic [ADDR_W-1:0] jump_pc,
    input  logic              branch_valid,
    input  logic [ADDR_W-1:0] branch_pc,
    input  logic              call_valid,
    input  logic [ADDR_W-1:0] call_ret_addr,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus,
    output logic              redirect_pend,
    output logic              ras_empty,
    output logic              ras_full
);

    localparam logic [ADDR_W-1:0] Incr = ADDR_W'(INSTR_BYTES);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              pend_q, pend_d;
    src_e              cap_src_q, cap_src_d;
    logic [ADDR_W-1:0] cap_tgt_q, cap_tgt_d;

    src_e              live_src;
    logic [ADDR_W-1:0] live_tgt;
    logic [ADDR_W-1:0] ras_top;
    logic [ADDR_W-1:0] ret_tgt;

    ras_stack #(
        .RAS_DEPTH (RAS_DEPTH),
        .ADDR_W    (ADDR_W)
    ) u_ras (
        .clk     (clk),
        .rst     (rst),
        .push_i  (call_valid),
        .pop_i   (ret_valid),
        .clear_i (flush_valid),
        .data_i  (call_ret_addr),
        .top_o   (ras_top),
        .empty_o (ras_empty),
        .full_o  (ras_full)
    );

    assign pc            = pc_q;
    assign pc_plus       = pc_q + Incr;
    assign redirect_pend = pend_q;
    assign ret_tgt       = ras_empty ? ret_fallback : ras_top;

    always_comb begin
        live_src = SRC_NONE;
        live_tgt = '0;
        if (flush_valid) begin
            live_src = SRC_FLUSH;
            live_tgt = flush_pc;
        end else if (ret_valid) begin
            live_src = SRC_RET;
            live_tgt = ret_tgt;
        end else if (jump_valid) begin
            live_src = SRC_JUMP;
            live_tgt = jump_pc;
        end else if (branch_valid) begin
            live_src = SRC_BRANCH;
            live_tgt = branch_pc;
        end
    end

    always_comb begin
        pc_d      = pc_q;
        pend_d    = pend_q;
        cap_src_d = cap_src_q;
        cap_tgt_d = cap_tgt_q;
        if (!stall) begin
            pend_d = 1'b0;
            if (live_src != SRC_NONE) begin
                pc_d = live_tgt;
            end else if (pend_q) begin
                pc_d = cap_tgt_q;
            end else begin
                pc_d = pc_plus;
            end
        end else if (live_src != SRC_NONE && (!pend_q || live_src >= cap_src_q)) begin
            // Equal priority overwrites: the newest redirect of a class is the relevant one.
            pend_d    = 1'b1;
            cap_src_d = live_src;
            cap_tgt_d = live_tgt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_VEC;
            pend_q    <= 1'b0;
            cap_src_q <= SRC_NONE;
            cap_tgt_q <= '0;
        end else begin
            pc_q      <= pc_d;
            pend_q    <= pend_d;
            cap_src_q <= cap_src_d;
            cap_tgt_q <= cap_tgt_d;
        end
    end

endmodule

// File: tb/tb_pc_gen_ras.sv
// Directed bench for pc_gen_ras: queue-based reference model checked every
// cycle, plus literal expectations on the directed scenarios.
module tb_pc_gen_ras;

    localparam logic [31:0] RV    = 32'h100;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, stall;
    logic        flush_valid, ret_valid, jump_valid, branch_valid, call_valid;
    logic [31:0] flush_pc, ret_fallback, jump_pc, branch_pc, call_ret_addr;
    logic [31:0] pc, pc_plus;
    logic        redirect_pend, ras_empty, ras_full;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic        m_pend;
    int          m_cap_rank;
    logic [31:0] m_cap;
    logic [31:0] ras_q[$];
    bit          m_ok = 1'b0;

    pc_gen_ras #(
        .ADDR_W      (32),
        .RESET_VEC   (RV),
        .INSTR_BYTES (4),
        .RAS_DEPTH   (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush_valid   (flush_valid),
        .flush_pc      (flush_pc),
        .ret_valid     (ret_valid),
        .ret_fallback  (ret_fallback),
        .jump_valid    (jump_valid),
        .jump_pc       (jump_pc),
        .branch_valid  (branch_valid),
        .branch_pc     (branch_pc),
        .call_valid    (call_valid),
        .call_ret_addr (call_ret_addr),
        .pc            (pc),
        .pc_plus       (pc_plus),
        .redirect_pend (redirect_pend),
        .ras_empty     (ras_empty),
        .ras_full      (ras_full)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_step();
        int          rank;
        logic [31:0] tgt;
        logic [31:0] rtop;
        if (rst) begin
            m_pc = RV;
            m_pend = 1'b0;
            m_cap_rank = 0;
            ras_q.delete();
            m_ok = 1'b1;
            return;
        end
        rtop = (ras_q.size() != 0) ? ras_q[ras_q.size()-1] : ret_fallback;
        rank = 0;
        tgt  = '0;
        if (flush_valid)       begin rank = 4; tgt = flush_pc;  end
        else if (ret_valid)    begin rank = 3; tgt = rtop;      end
        else if (jump_valid)   begin rank = 2; tgt = jump_pc;   end
        else if (branch_valid) begin rank = 1; tgt = branch_pc; end
        if (!stall) begin
            if (rank > 0)    m_pc = tgt;
            else if (m_pend) m_pc = m_cap;
            else             m_pc = m_pc + 32'd4;
            m_pend = 1'b0;
        end else if (rank > 0 && (!m_pend || rank >= m_cap_rank)) begin
            m_cap = tgt;
            m_cap_rank = rank;
            m_pend = 1'b1;
        end
        if (flush_valid) begin
            ras_q.delete();
        end else if (call_valid && ret_valid) begin
            if (ras_q.size() == 0) ras_q.push_back(call_ret_addr);
            else ras_q[ras_q.size()-1] = call_ret_addr;
        end else if (call_valid) begin
            if (ras_q.size() == DEPTH) void'(ras_q.pop_front());
            ras_q.push_back(call_ret_addr);
        end else if (ret_valid && ras_q.size() != 0) begin
            void'(ras_q.pop_back());
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (m_ok) begin
            check("model_pc", pc, m_pc);
            check("model_pc_plus", pc_plus, m_pc + 32'd4);
            check("model_pend", {31'b0, redirect_pend}, {31'b0, m_pend});
            check("model_empty", {31'b0, ras_empty}, {31'b0, ras_q.size() == 0});
            check("model_full", {31'b0, ras_full}, {31'b0, ras_q.size() == DEPTH});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        flush_valid = 0; ret_valid = 0; jump_valid = 0; branch_valid = 0; call_valid = 0;
    endtask

    initial begin
        rst = 1; stall = 0;
        clear_in();
        flush_pc = '0; ret_fallback = '0; jump_pc = '0; branch_pc = '0; call_ret_addr = '0;

        // Reset and sequential run
        tick();
        check("reset_pc", pc, 32'h100);
        check("reset_pend", {31'b0, redirect_pend}, 32'h0);
        check("reset_empty", {31'b0, ras_empty}, 32'h1);
        rst = 0;
        tick(); check("seq1", pc, 32'h104);
        tick(); check("seq2", pc, 32'h108);
        tick(); check("seq3", pc, 32'h10C);
        rst = 1;
        tick(); check("rst_mid_run", pc, 32'h100);
        rst = 0;
        stall = 1; branch_valid = 1; branch_pc = 32'h200;
        tick(); check("stall_pend", {31'b0, redirect_pend}, 32'h1);
        rst = 1;
        tick(); check("rst_mid_stall_pc", pc, 32'h100);
        check("rst_mid_stall_pend", {31'b0, redirect_pend}, 32'h0);
        rst = 0; stall = 0; clear_in();

        // Priority
        branch_valid = 1; branch_pc = 32'h40; jump_valid = 1; jump_pc = 32'h80;
        tick(); check("jump_over_branch", pc, 32'h80);
        flush_valid = 1; flush_pc = 32'hF00;
        tick(); check("flush_over_all", pc, 32'hF00);
        clear_in();

        // Stall capture
        stall = 1; branch_valid = 1; branch_pc = 32'h200;
        tick(); check("stall_hold1", pc, 32'hF00);
        branch_valid = 0; jump_valid = 1; jump_pc = 32'h300;
        tick(); check("stall_hold2", pc, 32'hF00);
        jump_valid = 0;
        tick(); check("stall_hold3", pc, 32'hF00);
        check("stall_pend3", {31'b0, redirect_pend}, 32'h1);
        stall = 0;
        tick(); check("release_jump", pc, 32'h300);
        check("release_pend", {31'b0, redirect_pend}, 32'h0);
        stall = 1; branch_valid = 1; branch_pc = 32'h500;
        tick();
        branch_valid = 0; flush_valid = 1; flush_pc = 32'h600;
        tick();
        flush_valid = 0; stall = 0;
        tick(); check("release_flush", pc, 32'h600);
        stall = 1; jump_valid = 1; jump_pc = 32'h900;
        tick();
        jump_valid = 0; branch_valid = 1; branch_pc = 32'hA00;
        tick();
        branch_valid = 0; stall = 0;
        tick(); check("lower_no_overwrite", pc, 32'h900);
        stall = 1; jump_valid = 1; jump_pc = 32'h700;
        tick();
        jump_valid = 0; stall = 0; branch_valid = 1; branch_pc = 32'h800;
        tick(); check("live_over_stale", pc, 32'h800);
        clear_in();
        tick(); check("after_live_seq", pc, 32'h804);

        // RAS fill, overflow and drain
        call_valid = 1;
        for (int i = 1; i <= 5; i++) begin
            call_ret_addr = 32'h10 * i;
            tick();
        end
        call_valid = 0;
        check("ras_full", {31'b0, ras_full}, 32'h1);
        ret_valid = 1; ret_fallback = 32'hBEEF0;
        tick(); check("ret1", pc, 32'h50);
        tick(); check("ret2", pc, 32'h40);
        tick(); check("ret3", pc, 32'h30);
        tick(); check("ret4", pc, 32'h20);
        check("ras_drained", {31'b0, ras_empty}, 32'h1);
        tick(); check("ret_fallback", pc, 32'hBEEF0);
        ret_valid = 0;

        // Simultaneous call + ret
        call_valid = 1; call_ret_addr = 32'h10;
        tick();
        call_ret_addr = 32'h20;
        tick();
        ret_valid = 1; call_ret_addr = 32'h60;
        tick(); check("callret_pc", pc, 32'h20);
        call_valid = 0;
        tick(); check("callret_next", pc, 32'h60);
        tick(); check("callret_count", pc, 32'h10);
        check("callret_empty", {31'b0, ras_empty}, 32'h1);
        ret_valid = 0;

        // PC wrap and flush clearing the RAS
        flush_valid = 1; flush_pc = 32'hFFFF_FFFC;
        tick(); check("wrap_pc", pc, 32'hFFFF_FFFC);
        check("wrap_pc_plus", pc_plus, 32'h0);
        flush_valid = 0;
        tick(); check("wrap_zero", pc, 32'h0);
        call_valid = 1; call_ret_addr = 32'h11;
        tick();
        call_ret_addr = 32'h22;
        tick();
        check("ras_two", {31'b0, ras_empty}, 32'h0);
        flush_valid = 1; flush_pc = 32'h40; call_ret_addr = 32'h33;
        tick(); check("flush_clears_ras", {31'b0, ras_empty}, 32'h1);
        check("flush_pc_ras", pc, 32'h40);
        clear_in();
        tick();
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
